// File: rtl/shop_pkg.sv
// Shared shop definitions: op codes, status codes, default widths and the admin name.
// Used by the item table controller, the command FSM and the user table.
package shop_pkg;

   localparam int NAME_BITS_DEF  = 24;
   localparam int STOCK_BITS_DEF = 8;

   localparam logic [23:0] ADMIN_NAME = "ADM";

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'd0,
      OP_ADD    = 2'd1,
      OP_DEL    = 2'd2,
      OP_BUY    = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_OK        = 3'd0,
      ST_NOT_FOUND = 3'd1,
      ST_EXISTS    = 3'd2,
      ST_FULL      = 3'd3,
      ST_NO_STOCK  = 3'd4
   } status_e;

endpackage

// File: rtl/shop_item_tbl_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping around.
// Produces a one-hot grant and its index; valid is low when nothing requests.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               valid
);

   int cand;

   // Walk offsets from the far end back to ptr so the closest requester wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      cand      = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shop_item_tbl_ctrl.sv
// Shop item table owner: round-robin grants one requester, scans all slots with fixed
// latency, executes LOOKUP/ADD/DEL/BUY atomically and returns status/stock with a 1-cycle ack.
module shop_item_tbl_ctrl
   import shop_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int NUM_ITEMS  = 8,
   parameter int NAME_BITS  = NAME_BITS_DEF,
   parameter int STOCK_BITS = STOCK_BITS_DEF
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*2-1:0]          i_op,
   input  logic [NUM_REQ*NAME_BITS-1:0]  i_name,
   input  logic [NUM_REQ*STOCK_BITS-1:0] i_qty,
   output logic [NUM_REQ-1:0]            o_ack,
   output logic [2:0]                    o_status,
   output logic [STOCK_BITS-1:0]         o_stock,
   output logic                          o_busy
);

   localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]            state;
   logic [NAME_BITS-1:0]  tbl_name  [NUM_ITEMS];
   logic [STOCK_BITS-1:0] tbl_stock [NUM_ITEMS];
   logic [NUM_ITEMS-1:0]  tbl_valid;

   logic [REQ_W-1:0]      rr_ptr;
   logic [REQ_W-1:0]      arb_idx;
   logic [NUM_REQ-1:0]    arb_grant;
   logic                  arb_valid;
   logic [NUM_REQ-1:0]    grant_oh;

   op_e                   cur_op;
   logic [NAME_BITS-1:0]  cur_name;
   logic [STOCK_BITS-1:0] cur_qty;
   logic [IDX_W-1:0]      scan_idx;
   logic                  hit;
   logic [IDX_W-1:0]      hit_idx;
   logic                  free_found;
   logic [IDX_W-1:0]      free_idx;

   op_e                   req_op;
   logic [NAME_BITS-1:0]  req_name;
   logic [STOCK_BITS-1:0] req_qty;
   logic [STOCK_BITS-1:0] hit_stock;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (REQ_W)
   ) u_arb (
      .req       (i_req),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   always_comb begin
      req_op    = op_e'(i_op[2*arb_idx +: 2]);
      req_name  = i_name[NAME_BITS*arb_idx +: NAME_BITS];
      req_qty   = i_qty[STOCK_BITS*arb_idx +: STOCK_BITS];
      hit_stock = tbl_stock[hit_idx];
   end

   assign o_busy = (state != S_IDLE);

   // Operands are latched at grant so requesters may change or drop them mid-op.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= S_IDLE;
         tbl_valid  <= '0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            tbl_name[i]  <= '0;
            tbl_stock[i] <= '0;
         end
         rr_ptr     <= '0;
         grant_oh   <= '0;
         cur_op     <= OP_LOOKUP;
         cur_name   <= '0;
         cur_qty    <= '0;
         scan_idx   <= '0;
         hit        <= 1'b0;
         hit_idx    <= '0;
         free_found <= 1'b0;
         free_idx   <= '0;
         o_ack      <= '0;
         o_status   <= ST_OK;
         o_stock    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_valid) begin
                  grant_oh   <= arb_grant;
                  cur_op     <= req_op;
                  cur_name   <= req_name;
                  cur_qty    <= req_qty;
                  rr_ptr     <= (arb_idx == REQ_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                  scan_idx   <= '0;
                  hit        <= 1'b0;
                  free_found <= 1'b0;
                  state      <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (tbl_valid[scan_idx] && (tbl_name[scan_idx] == cur_name) && !hit) begin
                  hit     <= 1'b1;
                  hit_idx <= scan_idx;
               end
               if (!tbl_valid[scan_idx] && !free_found) begin
                  free_found <= 1'b1;
                  free_idx   <= scan_idx;
               end
               if (scan_idx == IDX_W'(NUM_ITEMS - 1)) begin
                  state <= S_EXEC;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            S_EXEC: begin
               o_ack <= grant_oh;
               state <= S_RESP;
               case (cur_op)
                  OP_LOOKUP: begin
                     o_status <= hit ? ST_OK : ST_NOT_FOUND;
                     o_stock  <= hit ? hit_stock : '0;
                  end
                  OP_ADD: begin
                     if (hit) begin
                        o_status <= ST_EXISTS;
                        o_stock  <= hit_stock;
                     end else if (free_found) begin
                        tbl_name[free_idx]  <= cur_name;
                        tbl_stock[free_idx] <= cur_qty;
                        tbl_valid[free_idx] <= 1'b1;
                        o_status            <= ST_OK;
                        o_stock             <= cur_qty;
                     end else begin
                        o_status <= ST_FULL;
                        o_stock  <= '0;
                     end
                  end
                  OP_DEL: begin
                     if (hit) begin
                        tbl_valid[hit_idx] <= 1'b0;
                     end
                     o_status <= hit ? ST_OK : ST_NOT_FOUND;
                     o_stock  <= '0;
                  end
                  OP_BUY: begin
                     // Compare before subtracting so stock can never wrap.
                     if (!hit) begin
                        o_status <= ST_NOT_FOUND;
                        o_stock  <= '0;
                     end else if (cur_qty <= hit_stock) begin
                        tbl_stock[hit_idx] <= hit_stock - cur_qty;
                        o_status           <= ST_OK;
                        o_stock            <= hit_stock - cur_qty;
                     end else begin
                        o_status <= ST_NO_STOCK;
                        o_stock  <= hit_stock;
                     end
                  end
               endcase
            end
            S_RESP: begin
               o_ack <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shop_item_tbl_ctrl.sv
// Self-checking bench for shop_item_tbl_ctrl: table-driven single ops through a scoreboard,
// then round-robin fairness with two held requests and a reset during SCAN.
module tb_shop_item_tbl_ctrl;
   import shop_pkg::*;

   localparam int NUM_REQ    = 2;
   localparam int NUM_ITEMS  = 8;
   localparam int NAME_BITS  = 24;
   localparam int STOCK_BITS = 8;

   logic                          clk = 1'b0;
   logic                          reset = 1'b1;
   logic [NUM_REQ-1:0]            req = '0;
   logic [NUM_REQ*2-1:0]          op = '0;
   logic [NUM_REQ*NAME_BITS-1:0]  name = '0;
   logic [NUM_REQ*STOCK_BITS-1:0] qty = '0;
   logic [NUM_REQ-1:0]            ack;
   logic [2:0]                    status;
   logic [STOCK_BITS-1:0]         stock;
   logic                          busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          r;
      logic [1:0]  op;
      logic [23:0] nm;
      logic [7:0]  q;
      logic [2:0]  st;
      logic [7:0]  sk;
      bit          chk_sk;
   } vec_t;

   typedef struct {
      int          r;
      logic [2:0]  st;
      logic [7:0]  sk;
      bit          chk_sk;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];

   shop_item_tbl_ctrl #(
      .NUM_REQ    (NUM_REQ),
      .NUM_ITEMS  (NUM_ITEMS),
      .NAME_BITS  (NAME_BITS),
      .STOCK_BITS (STOCK_BITS)
   ) dut (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_req    (req),
      .i_op     (op),
      .i_name   (name),
      .i_qty    (qty),
      .o_ack    (ack),
      .o_status (status),
      .o_stock  (stock),
      .o_busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", what, act, exp_v);
      end
   endtask

   task automatic addVec(input int r, input logic [1:0] o, input logic [23:0] nm,
                         input logic [7:0] q, input logic [2:0] st, input logic [7:0] sk,
                         input bit chk_sk);
      vec_t v;
      v.r = r; v.op = o; v.nm = nm; v.q = q; v.st = st; v.sk = sk; v.chk_sk = chk_sk;
      vecs.push_back(v);
   endtask

   task automatic pushExp(input int r, input logic [2:0] st, input logic [7:0] sk, input bit chk_sk);
      exp_t e;
      e.r = r; e.st = st; e.sk = sk; e.chk_sk = chk_sk;
      sbq.push_back(e);
   endtask

   // Pops the oldest expectation and compares it with the ack currently on the outputs.
   task automatic checkOutput(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s unexpected_ack actual=%0b required=none", tag, ack);
      end else begin
         e = sbq.pop_front();
         check({tag, " ack"}, 32'(ack), 32'(1) << e.r);
         check({tag, " status"}, 32'(status), 32'(e.st));
         if (e.chk_sk) check({tag, " stock"}, 32'(stock), 32'(e.sk));
      end
   endtask

   // Drives one op on requester r, waits (bounded) for its ack and checks latency/result/hold.
   task automatic applyStimulus(input int r, input logic [1:0] o, input logic [23:0] nm,
                                input logic [7:0] q, input logic [2:0] st, input logic [7:0] sk,
                                input bit chk_sk, input string tag);
      int n;
      op[2*r +: 2]      = o;
      name[24*r +: 24]  = nm;
      qty[8*r +: 8]     = q;
      req[r]            = 1'b1;
      pushExp(r, st, sk, chk_sk);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      end while (ack == '0 && n < 40);
      req[r] = 1'b0;
      if (ack == '0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s ack_timeout actual=none required=ack_within_40", tag);
         sbq.delete();
      end else begin
         check({tag, " latency"}, 32'(n), 32'(NUM_ITEMS + 2));
         checkOutput(tag);
         @(posedge clk); #1;
         check({tag, " ack_clear"}, 32'(ack), 32'd0);
         check({tag, " status_hold"}, 32'(status), 32'(st));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int last_r;
      int first;
      int served[NUM_REQ];
      int cyc;
      int n_ack;
      int who;
      int cnt1;

      $display("[TB] starting");
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset ack", 32'(ack), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset status", 32'(status), 32'(ST_OK));
      check("reset stock", 32'(stock), 32'd0);

      addVec(0, OP_ADD,    "Pen", 8'd5, ST_OK,        8'd5, 1);
      addVec(0, OP_ADD,    "Pen", 8'd9, ST_EXISTS,    8'd5, 1);
      addVec(1, OP_LOOKUP, "Cup", 8'd0, ST_NOT_FOUND, 8'd0, 1);
      addVec(1, OP_BUY,    "Pen", 8'd3, ST_OK,        8'd2, 1);
      addVec(1, OP_BUY,    "Pen", 8'd3, ST_NO_STOCK,  8'd2, 1);
      addVec(1, OP_BUY,    "Pen", 8'd2, ST_OK,        8'd0, 1);
      addVec(0, OP_BUY,    "Pen", 8'd0, ST_OK,        8'd0, 1);
      addVec(0, OP_DEL,    "Cup", 8'd0, ST_NOT_FOUND, 8'd0, 0);
      addVec(1, OP_BUY,    "Cup", 8'd1, ST_NOT_FOUND, 8'd0, 0);
      for (int k = 1; k <= 7; k++)
         addVec(k % 2, OP_ADD, {"It", 8'(48 + k)}, 8'(10 + k), ST_OK, 8'(10 + k), 1);
      addVec(0, OP_ADD,    "Zz9", 8'd4,  ST_FULL,      8'd0,  1);
      addVec(1, OP_ADD,    "It5", 8'd1,  ST_EXISTS,    8'd15, 1);
      addVec(1, OP_LOOKUP, "It3", 8'd0,  ST_OK,        8'd13, 1);
      addVec(0, OP_DEL,    "It3", 8'd0,  ST_OK,        8'd0,  1);
      addVec(1, OP_LOOKUP, "It3", 8'd0,  ST_NOT_FOUND, 8'd0,  1);
      addVec(0, OP_ADD,    "Nw3", 8'd7,  ST_OK,        8'd7,  1);
      addVec(1, OP_LOOKUP, "Nw3", 8'd0,  ST_OK,        8'd7,  1);
      addVec(1, OP_ADD,    "Zz9", 8'd1,  ST_FULL,      8'd0,  1);
      addVec(0, OP_LOOKUP, "It7", 8'd0,  ST_OK,        8'd17, 1);

      last_r = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].r, vecs[i].op, vecs[i].nm, vecs[i].q,
                       vecs[i].st, vecs[i].sk, vecs[i].chk_sk, $sformatf("v%0d", i));
         last_r = vecs[i].r;
      end

      // Both requesters held together: grants must alternate starting after the last winner.
      first = (last_r + 1) % NUM_REQ;
      cnt1  = 0;
      for (int k = 0; k < 8; k++) begin
         who = (first + k) % NUM_REQ;
         if (who == 0) begin
            pushExp(0, ST_OK, 8'd11, 1);
         end else begin
            cnt1++;
            pushExp(1, ST_OK, 8'(12 - cnt1), 1);
         end
      end
      op[1:0]   = OP_LOOKUP; name[23:0]  = "It1"; qty[7:0]  = 8'd0;
      op[3:2]   = OP_BUY;    name[47:24] = "It2"; qty[15:8] = 8'd1;
      served[0] = 0;
      served[1] = 0;
      req       = 2'b11;
      cyc       = 0;
      while (sbq.size() > 0 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (ack != '0) begin
            checkOutput($sformatf("rr%0d", served[0] + served[1]));
            who = ack[1] ? 1 : 0;
            served[who]++;
            if (served[who] == 4) req[who] = 1'b0;
         end
      end
      req = '0;
      if (sbq.size() > 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL rr_timeout actual=%0d_pending required=0", sbq.size());
         sbq.delete();
      end
      @(posedge clk); #1;

      // Reset while an ADD is scanning: no ack, idle at once, table cleared.
      op[1:0] = OP_ADD; name[23:0] = "Rst"; qty[7:0] = 8'd4;
      req[0]  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst scan_busy", 32'(busy), 32'd1);
      reset  = 1'b1;
      req[0] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst busy", 32'(busy), 32'd0);
      check("rst ack", 32'(ack), 32'd0);
      check("rst stock", 32'(stock), 32'd0);
      n_ack = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (ack != '0) n_ack++;
      end
      check("rst no_late_ack", 32'(n_ack), 32'd0);
      applyStimulus(1, OP_LOOKUP, "Rst", 8'd0, ST_NOT_FOUND, 8'd0, 1, "rst_lookup_rst");
      applyStimulus(0, OP_LOOKUP, "Pen", 8'd0, ST_NOT_FOUND, 8'd0, 1, "rst_lookup_pen");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
